m_imem_loader: RTL and testbench
================================

# m_imem_loader

Serial program loader that sits directly upstream of the processor's instruction memory. It receives a program over a UART line (8N1), assembles bytes into 32-bit instruction words, and issues single-cycle word writes (address, data, strobe) into the memory write port. When loading finishes it raises a sticky done flag that the top level uses to release the processor from reset.

## Interface
- SERIAL_WAIT, 434: clocks per UART bit period (50 MHz / 115200); must be ≥ 4.
- LOAD_WORDS, 4096: maximum number of words written before done is forced.
- w_clk  in  1  system clock; all logic on its rising edge.
- w_rst  in  1  reset; synchronous, active-high.
- w_rxd  in  1  asynchronous serial input, idle high.
- r_we  out  1  memory write strobe, one-cycle pulse per word.
- r_addr  out  12  word address for the current write.
- r_data  out  32  word data for the current write.
- r_done  out  1  load complete, sticky.
- r_err  out  1  framing error seen, sticky.

## Operation
- Input sync: w_rxd passes through a 2-flop synchronizer; both flops reset to 1. All sampling uses the synchronized bit.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for synchronized line = 0 → START, bit counter cleared.
  - START: wait SERIAL_WAIT/2 clocks. If line is still 0 → DATA. Otherwise it was a glitch → IDLE, with no error.
  - DATA: sample every SERIAL_WAIT clocks, 8 bits, LSB first, into a shift register. After bit 7 → STOP.
  - STOP: wait SERIAL_WAIT clocks, then sample.
    - Sample = 1: byte accepted, → IDLE.
    - Sample = 0: byte discarded, r_err ← 1, → IDLE.
- Word assembly: the first accepted byte of a word is bits [31:24] (big-endian); the 4th byte is bits [7:0]. A 2-bit byte counter wraps 3→0.
- On the 4th accepted byte:
  - If the word is 32'hFFFFFFFF (terminator): no write, r_done ← 1.
  - Otherwise: r_data ← word, r_we ← 1 for one cycle at the current r_addr. r_addr increments by 1 the cycle after the strobe.
  - If that write was word number LOAD_WORDS: r_done ← 1 in the same cycle as r_addr's increment. r_addr wraps to 0 at LOAD_WORDS = 4096 and is irrelevant once done.
- Once r_done = 1, the RX FSM keeps running, but accepted bytes are ignored. No further r_we, no address or error change.
- A framing error does not advance the byte counter; the partial word is kept.

## Timing
- Reset values: r_we = 0, r_addr = 0, r_data = 0, r_done = 0, r_err = 0. The FSM is in IDLE, byte counter = 0, shift register = 0.
- Reset asserted mid-byte or mid-word: everything returns to its reset value on the next edge. The partial word is discarded, and done/err are cleared.
- Latency: r_we rises exactly 1 clock after the edge where the 4th byte's stop bit is sampled as 1. r_data and r_addr are stable during that same cycle.
- Terminator: r_done rises 1 clock after its stop-bit sample.
- Minimum spacing of r_we pulses: 4 frames, 40·SERIAL_WAIT clocks. No back-pressure; the memory must accept a write every cycle that r_we is high.
- Stop-bit edge: the sample point is the mid-bit of the stop bit. A new start edge arriving immediately after that sample is detected normally, so back-to-back frames with no idle gap are supported.
- Simultaneous events: w_rst overrides everything. A write and the done assertion caused by LOAD_WORDS can share a cycle; the write still occurs.

## Test plan
- SERIAL_WAIT=8, bytes 20 01 00 20 sent → one r_we pulse with r_addr=0, r_data=32'h20010020; afterwards r_addr=1 and r_done=0.
- SERIAL_WAIT=8, two words (00000000, 2000000A) followed by FF FF FF FF, sent back-to-back with no idle gap → writes at addr 0 and 1; r_done=1 one clock after the final stop sample; r_addr=2; no third r_we.
- SERIAL_WAIT=8, LOAD_WORDS=3, five words sent → exactly 3 writes (addr 0–2); r_done=1; later bytes cause no r_we and no address change.
- SERIAL_WAIT=8: send byte 0x55 with stop bit forced 0, then bytes 11 22 33 44 → r_err=1; one write of r_data=32'h11223344 at addr 0.
- SERIAL_WAIT=8: a 2-clock low glitch on w_rxd → no byte accepted and r_err=0. Separately, assert w_rst after 2 bytes of a word, then send a full word AABBCCDD → write at addr 0 with data 32'hAABBCCDD.
- Reset check: after any of the above, hold w_rst for 1 cycle → all outputs 0 on the next edge.

Source files
------------

// File: rtl/m_imem_loader_if.sv
// m_imem_loader_if
//   Instruction-memory write port driven by the serial program loader.
//   The bundle also carries the loader's status flags, so the top level can
//   hold the processor in reset until the load is complete.
//
//   r_we    : one-cycle write strobe per instruction word
//   r_addr  : word address of the current write (12 bits)
//   r_data  : word data of the current write (32 bits)
//   r_done  : load complete, sticky until reset
//   r_err   : a UART framing error was seen, sticky until reset
//
//   master : loader side (drives everything)
//   slave  : memory / top-level side (observes everything)
interface m_imem_loader_if;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_data;
  logic        r_done;
  logic        r_err;

  modport master (output r_we, output r_addr, output r_data, output r_done, output r_err);
  modport slave  (input  r_we, input  r_addr, input  r_data, input  r_done, input  r_err);
endinterface

// File: rtl/m_imem_loader.sv
// m_imem_loader
//   Serial program loader placed in front of the instruction memory. It
//   receives 8N1 UART bytes, packs them big-endian into 32-bit words, and
//   writes each word into the memory one word per address, starting at 0.
//   The word 32'hFFFFFFFF ends the load without being written. The load also
//   ends by itself after LOAD_WORDS writes. Once it has ended, r_done stays
//   high and later traffic is ignored.
//
//   Parameters
//     SERIAL_WAIT : clocks per UART bit period (must be >= 4)
//     LOAD_WORDS  : maximum number of words written before done is forced
//
//   Ports
//     w_clk  : system clock, rising edge
//     w_rst  : synchronous active-high reset
//     w_rxd  : asynchronous serial input, idle high
//     mem    : write port and status flags (m_imem_loader_if.master)
module m_imem_loader #(
  parameter int SERIAL_WAIT = 434,
  parameter int LOAD_WORDS  = 4096
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_rxd,
  m_imem_loader_if.master        mem
);

  localparam int              CNT_W     = $clog2(SERIAL_WAIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(SERIAL_WAIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SERIAL_WAIT / 2 - 1);
  localparam logic [11:0]      LAST_ADDR = 12'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  logic             rxd_meta;
  logic             rxd_sync;

  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_next;
  logic [7:0]       shift_q;
  logic [7:0]       shift_next;
  logic             byte_ok;
  logic             byte_ok_next;
  logic             frame_bad;
  logic             frame_bad_next;

  logic [1:0]       byte_cnt;
  logic [23:0]      word_hi;
  logic             we_q;
  logic [11:0]      addr_q;
  logic [31:0]      data_q;
  logic             done_q;
  logic             err_q;

  // Two-flop synchronizer. Both flops reset to the idle-high level, so
  // reset can never look like a start bit.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= w_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Receiver state register. byte_ok and frame_bad are one-cycle pulses
  // raised on the edge where the stop bit is sampled.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_q   <= 8'h00;
      byte_ok   <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_q   <= shift_next;
      byte_ok   <= byte_ok_next;
      frame_bad <= frame_bad_next;
    end
  end

  // Receiver next-state logic. The start bit is checked half a bit period
  // after the falling edge. Every later sample is one full period on, which
  // puts it mid-bit. The receiver returns to IDLE right at the stop-bit
  // sample, so a start edge that follows the stop bit with no gap is still
  // seen.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt + 1'b1;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_q;
    byte_ok_next   = 1'b0;
    frame_bad_next = 1'b0;

    case (state)
      IDLE: begin
        wait_cnt_next = '0;
        if (!rxd_sync) begin
          state_next   = START;
          bit_cnt_next = 3'd0;
        end
      end

      START: begin
        if (wait_cnt == HALF_LAST) begin
          wait_cnt_next = '0;
          // A line that is high again was only a glitch; drop it silently.
          state_next    = rxd_sync ? IDLE : DATA;
        end
      end

      DATA: begin
        if (wait_cnt == FULL_LAST) begin
          wait_cnt_next = '0;
          shift_next    = {rxd_sync, shift_q[7:1]};
          bit_cnt_next  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (wait_cnt == FULL_LAST) begin
          wait_cnt_next = '0;
          state_next    = IDLE;
          if (rxd_sync) begin
            byte_ok_next = 1'b1;
          end else begin
            frame_bad_next = 1'b1;
          end
        end
      end

      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Word assembly and memory write. The address advances on the cycle after
  // the strobe, so r_addr and r_data hold steady while r_we is high. A bad
  // frame does not advance the byte counter, so the partial word survives.
  // The write that reaches LOAD_WORDS still happens; done rises together
  // with the address increment that follows it.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      byte_cnt <= 2'd0;
      word_hi  <= 24'h000000;
      we_q     <= 1'b0;
      addr_q   <= 12'h000;
      data_q   <= 32'h00000000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;

      if (we_q) begin
        addr_q <= addr_q + 12'd1;
        if (addr_q == LAST_ADDR) begin
          done_q <= 1'b1;
        end
      end

      if (!done_q) begin
        if (frame_bad) begin
          err_q <= 1'b1;
        end
        if (byte_ok) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if ({word_hi, shift_q} == 32'hFFFFFFFF) begin
              done_q <= 1'b1;
            end else begin
              we_q   <= 1'b1;
              data_q <= {word_hi, shift_q};
            end
          end else begin
            word_hi <= {word_hi[15:0], shift_q};
          end
        end
      end
    end
  end

  assign mem.r_we   = we_q;
  assign mem.r_addr = addr_q;
  assign mem.r_data = data_q;
  assign mem.r_done = done_q;
  assign mem.r_err  = err_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// tb_m_imem_loader
//   Bench for m_imem_loader with SERIAL_WAIT=8 and LOAD_WORDS=3. Serial
//   frames are driven on falling clock edges. A reference model predicts
//   every memory write and pushes it to a scoreboard queue. A monitor pops
//   that queue on each observed r_we pulse.
module tb_m_imem_loader;

  localparam int SW = 8;
  localparam int LW = 3;

  logic w_clk;
  logic w_rst;
  logic w_rxd;

  m_imem_loader_if bus ();

  m_imem_loader #(
    .SERIAL_WAIT (SW),
    .LOAD_WORDS  (LW)
  ) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_rxd (w_rxd),
    .mem   (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model
  logic [43:0] sb[$];
  int          m_addr;
  logic        m_done;
  logic        m_err;
  int          m_cnt;
  logic [31:0] m_word;
  logic        prev_we;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_addr = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_word = 32'h0;
  endtask

  task automatic send_bit(input logic v);
    w_rxd = v;
    repeat (SW) @(negedge w_clk);
  endtask

  // One 8N1 frame; the model is updated before the frame goes out.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    if (!m_done) begin
      if (!stop_bit) begin
        m_err = 1'b1;
      end else begin
        m_word = {m_word[23:0], b};
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt = 0;
          if (m_word == 32'hFFFFFFFF) begin
            m_done = 1'b1;
          end else begin
            sb.push_back({12'(m_addr), m_word});
            m_addr++;
            if (m_addr == LW) m_done = 1'b1;
          end
        end
      end
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[31-8*i -: 8], 1'b1);
  endtask

  task automatic idle(input int bits);
    w_rxd = 1'b1;
    repeat (bits * SW) @(negedge w_clk);
  endtask

  task automatic reset_dut(input string tag);
    w_rst = 1'b1;
    w_rxd = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    model_reset();
    checkOutput({tag, "_rst_we"},   {31'd0, bus.r_we},   32'd0);
    checkOutput({tag, "_rst_addr"}, {20'd0, bus.r_addr}, 32'd0);
    checkOutput({tag, "_rst_data"}, bus.r_data,          32'd0);
    checkOutput({tag, "_rst_done"}, {31'd0, bus.r_done}, 32'd0);
    checkOutput({tag, "_rst_err"},  {31'd0, bus.r_err},  32'd0);
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, "_addr"},    {20'd0, bus.r_addr}, 32'(12'(m_addr)));
    checkOutput({tag, "_done"},    {31'd0, bus.r_done}, {31'd0, m_done});
    checkOutput({tag, "_err"},     {31'd0, bus.r_err},  {31'd0, m_err});
    checkOutput({tag, "_pending"}, 32'(sb.size()),      32'd0);
  endtask

  // Write monitor: every strobe must match the oldest predicted write and
  // must be a single-cycle pulse.
  always @(negedge w_clk) begin
    if (!w_rst && bus.r_we) begin
      logic [43:0] exp_wr;
      checkOutput("we_single", {31'd0, prev_we}, 32'd0);
      checkOutput("we_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_wr = sb.pop_front();
        checkOutput("wr_addr", {20'd0, bus.r_addr}, {20'd0, exp_wr[43:32]});
        checkOutput("wr_data", bus.r_data, exp_wr[31:0]);
      end
    end
    prev_we = bus.r_we;
  end

  initial begin
    prev_we = 1'b0;
    w_rst   = 1'b1;
    w_rxd   = 1'b1;
    model_reset();
    repeat (3) @(negedge w_clk);
    reset_dut("init");

    // single word
    send_word(32'h20010020);
    idle(2);
    check_state("one_word");

    // two words and the terminator, back to back
    reset_dut("t2");
    send_word(32'h00000000);
    send_word(32'h2000000A);
    idle(2);
    check_state("two_words");
    send_word(32'hFFFFFFFF);
    idle(2);
    check_state("terminator");

    // write limit: five words, only LW written
    reset_dut("t3");
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    send_word(32'h0BADF00D);
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    idle(2);
    check_state("limit");

    // framing error then a good word
    reset_dut("t4");
    applyStimulus(8'h55, 1'b0);
    idle(2);
    check_state("frame_err");
    send_word(32'h11223344);
    idle(2);
    check_state("after_err");

    // glitch, then a word that would be misaligned if the glitch counted
    reset_dut("t5");
    w_rxd = 1'b0;
    repeat (2) @(negedge w_clk);
    idle(4);
    check_state("glitch");
    send_word(32'h01020304);
    idle(2);
    check_state("post_glitch");

    // reset with a partial word and a frame in flight
    applyStimulus(8'hDE, 1'b1);
    applyStimulus(8'hAD, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_dut("mid");
    idle(2);
    send_word(32'hAABBCCDD);
    idle(2);
    check_state("after_mid_rst");

    // final one-cycle reset
    reset_dut("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
